hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sits beside the forwarding logic.
- Detects load-use hazards, sequences the multi-cycle mult/div unit's occupancy, and applies taken-branch flushes.
- Drives the PC write-enable, IF/ID write-enable, IF/ID flush and ID/EX bubble controls.
- Contains the only pipeline-control state: the mult/div busy FSM, its countdown counter, and the stall statistics counter.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit stays busy after a mult/div issues into EX; legal range 1..63.
- CNT_W, 6, width of the mult/div countdown counter; must hold MD_LATENCY.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_Ex_MemRead  in  1  instruction in EX is a load.
- ID_Ex_Rt  in  5  destination register of the load in EX.
- IF_Id_Rs  in  5  rs of the instruction in ID.
- IF_Id_Rt  in  5  rt of the instruction in ID.
- IF_Id_UsesRt  in  1  instruction in ID reads rt as a source.
- IF_Id_MdStart  in  1  instruction in ID is mult/multu/div/divu.
- IF_Id_MdRead  in  1  instruction in ID is mfhi/mflo.
- Ex_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- PCWrite  out  1  PC register load enable.
- IF_IdWrite  out  1  IF/ID register load enable.
- IF_IdFlush  out  1  clear IF/ID to a NOP.
- ID_ExBubble  out  1  zero all control bits entering ID/EX.
- MdBusy  out  1  mult/div unit occupied.
- StallCount  out  STAT_W  saturating count of stall cycles.

Behaviour:
Reset (rst_n=0, asynchronous):
- State = RUN; md_cnt = 0; StallCount = 0; MdBusy = 0.
- While reset is held: PCWrite=0, IF_IdWrite=0, IF_IdFlush=1, ID_ExBubble=1.
- Reset asserted mid-operation abandons any mult/div occupancy immediately.

Hazard terms (combinational, same cycle):
- load_use = ID_Ex_MemRead & (ID_Ex_Rt!=0) & ((ID_Ex_Rt==IF_Id_Rs) | (IF_Id_UsesRt & (ID_Ex_Rt==IF_Id_Rt))).
- md_hazard = MdBusy & (IF_Id_MdRead | IF_Id_MdStart).
- stall = (load_use | md_hazard) & ~Ex_BranchTaken.

Output decode (combinational from state and inputs), in priority order:
1. Ex_BranchTaken → PCWrite=1, IF_IdWrite=1, IF_IdFlush=1, ID_ExBubble=1. Overrides every stall; the ID instruction is squashed.
2. stall → PCWrite=0, IF_IdWrite=0, IF_IdFlush=0, ID_ExBubble=1.
3. Otherwise → PCWrite=1, IF_IdWrite=1, IF_IdFlush=0, ID_ExBubble=0.

Mult/div acceptance:
- md_accept = IF_Id_MdStart & ~stall & ~Ex_BranchTaken. The mult/div advances into EX this cycle.

FSM (RUN, MD_BUSY):
- RUN: on md_accept, load md_cnt = MD_LATENCY and go to MD_BUSY. Otherwise stay.
- MD_BUSY: decrement md_cnt every cycle. When md_cnt reaches 1 and then decrements, go to RUN the next edge.
- A branch flush never cancels MD_BUSY, because the mult/div already left ID.
- A second mult/div cannot be accepted while busy: it stalls via md_hazard.
- MdBusy = (state==MD_BUSY). It is high for exactly MD_LATENCY cycles, beginning the cycle after md_accept.
- Back-to-back issue: a mult/div in ID on the final busy cycle still stalls. It is accepted the first cycle MdBusy=0, giving one idle cycle between occupancies.

Load-use stalls:
- Self-limiting to one cycle: the bubble removes the load from EX on the next edge.
- A load-use stall coinciding with MD_BUSY stalls once; the busy countdown continues during any stall.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: StallCount increments by 1 on each clock edge where stall=1 (reset excluded) and saturates at all-ones.
- Undefined: the counter logic is omitted and StallCount is tied to 0.

Test Plan:
- Load-use on rs: ID_Ex_MemRead=1, ID_Ex_Rt=8, IF_Id_Rs=8 → PCWrite=0, IF_IdWrite=0, ID_ExBubble=1 for one cycle. With HAZ_STATS_EN, StallCount 0→1.
- Load to $0: ID_Ex_MemRead=1, ID_Ex_Rt=0, IF_Id_Rs=0 → no stall, PCWrite=1. Separately, ID_Ex_Rt=9, IF_Id_Rt=9, IF_Id_UsesRt=0 → no stall.
- Mult/div occupancy, MD_LATENCY=4: mult accepted at cycle 0 → MdBusy=1 cycles 1–4. mflo in ID at cycle 2 → stalls cycles 2–4, accepted at cycle 5.
- Branch vs. stall: Ex_BranchTaken=1 together with a load_use match → IF_IdFlush=1, ID_ExBubble=1, PCWrite=1, StallCount unchanged. Branch=1 with IF_Id_MdStart=1 → MdBusy stays 0.
- Reset mid-busy: rst_n=0 at busy cycle 2 → MdBusy=0 and StallCount=0 immediately. After release, mflo proceeds with no stall.
- Saturation with STAT_W=4 and HAZ_STATS_EN: 20 consecutive stall cycles → StallCount holds 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use detection, mult/div occupancy, branch flush.
// Define HAZ_STATS_EN to build the saturating stall-cycle counter; otherwise StallCount is 0.
module hazard_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Ex_MemRead,
  input  logic [4:0]        ID_Ex_Rt,
  input  logic [4:0]        IF_Id_Rs,
  input  logic [4:0]        IF_Id_Rt,
  input  logic              IF_Id_UsesRt,
  input  logic              IF_Id_MdStart,
  input  logic              IF_Id_MdRead,
  input  logic              Ex_BranchTaken,
  output logic              PCWrite,
  output logic              IF_IdWrite,
  output logic              IF_IdFlush,
  output logic              ID_ExBubble,
  output logic              MdBusy,
  output logic [STAT_W-1:0] StallCount
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state, stateNxt;
  logic [CNT_W-1:0] mdCnt, mdCntNxt;
  logic             loadUse, mdHazard, stall, mdAccept;

  assign MdBusy   = (state == MD_BUSY);
  assign loadUse  = ID_Ex_MemRead & (ID_Ex_Rt != 5'd0) &
                    ((ID_Ex_Rt == IF_Id_Rs) | (IF_Id_UsesRt & (ID_Ex_Rt == IF_Id_Rt)));
  assign mdHazard = MdBusy & (IF_Id_MdRead | IF_Id_MdStart);
  assign stall    = (loadUse | mdHazard) & ~Ex_BranchTaken;
  assign mdAccept = IF_Id_MdStart & ~stall & ~Ex_BranchTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      mdCnt <= '0;
    end else begin
      state <= stateNxt;
      mdCnt <= mdCntNxt;
    end
  end

  // Countdown keeps running through stalls and flushes; the op already left ID.
  always_comb begin
    stateNxt = state;
    mdCntNxt = mdCnt;
    case (state)
      RUN: if (mdAccept) begin
        stateNxt = MD_BUSY;
        mdCntNxt = CNT_W'(MD_LATENCY);
      end
      MD_BUSY: begin
        mdCntNxt = mdCnt - CNT_W'(1);
        if (mdCnt == CNT_W'(1)) stateNxt = RUN;
      end
      default: stateNxt = RUN;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_IdWrite  = 1'b1;
    IF_IdFlush  = 1'b0;
    ID_ExBubble = 1'b0;
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IF_IdWrite  = 1'b0;
      IF_IdFlush  = 1'b1;
      ID_ExBubble = 1'b1;
    end else if (Ex_BranchTaken) begin
      IF_IdFlush  = 1'b1;
      ID_ExBubble = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IF_IdWrite  = 1'b0;
      ID_ExBubble = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        StallCount <= '0;
    else if (stall && (~StallCount != '0)) StallCount <= StallCount + STAT_W'(1);
  end
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller against a cycle-level model.
module tb_hazard_stall_controller;
  localparam int L      = 4;
  localparam int STAT_W = 4;
  localparam int SATMAX = (1 << STAT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic memRead, usesRt, mdStart, mdRead, br;
  logic [4:0] exRt, rs, rt;
  logic pcW, ifW, flush, bubble, busy;
  logic [STAT_W-1:0] cnt;

  int errors = 0, checks = 0;
  int mdLeft = 0;  // cycles of occupancy still to come
  int stalls = 0;  // stall cycles seen since reset

  always #5 clk = ~clk;

  hazard_stall_controller #(.MD_LATENCY(L), .CNT_W(6), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Ex_MemRead(memRead), .ID_Ex_Rt(exRt),
    .IF_Id_Rs(rs), .IF_Id_Rt(rt), .IF_Id_UsesRt(usesRt), .IF_Id_MdStart(mdStart),
    .IF_Id_MdRead(mdRead), .Ex_BranchTaken(br), .PCWrite(pcW), .IF_IdWrite(ifW),
    .IF_IdFlush(flush), .ID_ExBubble(bubble), .MdBusy(busy), .StallCount(cnt));

  function automatic logic modelStall();
    logic lu, mh;
    lu = memRead && exRt != 0 && (exRt == rs || (usesRt && exRt == rt));
    mh = (mdLeft > 0) && (mdRead || mdStart);
    return (lu || mh) && !br;
  endfunction

  function automatic logic [8:0] modelExp();
    logic [3:0] c;
    logic [3:0] ctl;
`ifdef HAZ_STATS_EN
    c = (stalls > SATMAX) ? 4'(SATMAX) : 4'(stalls);
`else
    c = 4'd0;
`endif
    if (!rst_n)            ctl = 4'b0011;
    else if (br)           ctl = 4'b1111;
    else if (modelStall()) ctl = 4'b0001;
    else                   ctl = 4'b1100;
    return {ctl, (mdLeft > 0), c};
  endfunction

  // Advance the model across the coming rising edge.
  task automatic modelTick();
    logic s;
    s = modelStall();
    if (!rst_n) begin
      mdLeft = 0; stalls = 0;
    end else begin
      if (mdLeft > 0) mdLeft--;
      else if (mdStart && !s && !br) mdLeft = L;
      if (s) stalls++;
    end
  endtask

  function automatic logic [8:0] obs();
    return {pcW, ifW, flush, bubble, busy, cnt};
  endfunction

  task automatic drive(input logic m, input logic [4:0] er, input logic [4:0] s,
                       input logic [4:0] t, input logic u, input logic ms,
                       input logic mr, input logic b);
    memRead = m; exRt = er; rs = s; rt = t; usesRt = u; mdStart = ms; mdRead = mr; br = b;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 9'b0011_0_0000) begin
      errors++; $display("FAIL reset_hold got=%b want=%b", obs(), 9'b0011_0_0000);
    end
    modelTick();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    // rs match, then load leaves EX, then $0 target, then rt match without UsesRt
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 8, 8, 3, 0, 0, 0, 0);
        1: drive(0, 0, 8, 3, 0, 0, 0, 0);
        2: drive(1, 0, 0, 0, 1, 0, 0, 0);
        default: drive(1, 9, 1, 9, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      e = modelExp(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), e);
      end
      if (i == 0) begin
        checks++;
        if ({pcW, ifW, bubble} !== 3'b001) begin
          errors++; $display("FAIL load_use_stall got=%b want=001", {pcW, ifW, bubble});
        end
      end
      modelTick(); @(posedge clk); #1;
    end
  endtask

  task automatic test_md_occupancy();
    logic [8:0] e;
    int busyCycles = 0, stallCycles = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0)      drive(0, 0, 0, 0, 0, 1, 0, 0);
      else if (c == 1) drive(0, 0, 0, 0, 0, 0, 0, 0);
      else if (c <= 5) drive(0, 0, 0, 0, 0, 0, 1, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = modelExp(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL md_occ[c%0d] got=%b want=%b", c, obs(), e);
      end
      if (busy === 1'b1) busyCycles++;
      if (pcW === 1'b0) stallCycles++;
      modelTick(); @(posedge clk); #1;
    end
    checks++;
    if (busyCycles != L || stallCycles != 3) begin
      errors++; $display("FAIL md_counts got busy=%0d stall=%0d want busy=%0d stall=3",
                         busyCycles, stallCycles, L);
    end
  endtask

  task automatic test_branch();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      drive(1, 8, 8, 0, 0, 0, 0, 1);
      else if (i == 1) drive(0, 0, 0, 0, 0, 1, 0, 1);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = modelExp(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL branch[%0d] got=%b want=%b", i, obs(), e);
      end
      modelTick(); @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [8:0] e;
    drive(1, 7, 7, 0, 0, 1, 0, 0);  // stall once to give the counter something
    @(negedge clk); modelTick(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); modelTick(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); modelTick(); @(posedge clk); #1;  // busy cycle 2 now
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, cnt} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_busy got=%b want=00000", {busy, cnt});
    end
    modelTick();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    e = modelExp(); checks++;
    if (obs() !== e || pcW !== 1'b1) begin
      errors++; $display("FAIL mflo_after_rst got=%b want=%b", obs(), e);
    end
    modelTick(); @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      @(negedge clk);
      e = modelExp(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL random[%0d] got=%b want=%b", i, obs(), e);
      end
      modelTick(); @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic [8:0] e;
    rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); modelTick(); rst_n = 1'b1; @(posedge clk); #1;
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    repeat (20) begin
      @(negedge clk); modelTick(); @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    e = modelExp(); checks++;
`ifdef HAZ_STATS_EN
    if (cnt !== 4'(SATMAX) || obs() !== e) begin
`else
    if (cnt !== 4'd0 || obs() !== e) begin
`endif
      errors++; $display("FAIL saturation got=%b want=%b", obs(), e);
    end
    modelTick(); @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md_occupancy();
    test_branch();
    test_reset_mid_busy();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
